lvds_phy_align_ctrl: RTL

Word-alignment controller for the LVDS PHY receive path. It watches decoded 10-bit words from the PHY deserializer and pulses `bitslip` until K28.5 commas land on word boundaries. It declares lock after a run of good commas and drops lock after a run of code errors. It sits between the LVDS PHY and the LTPI link-training state machine, which consumes `aligned` and `align_fail`.

---
 rtl/lvds_phy_align_pkg.sv | 31 +++
 rtl/lvds_phy_align_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lvds_phy_align_pkg.sv
// ============================================================================
// lvds_phy_align_pkg : shared types and constants for the LVDS word aligner
// Revision: 1.0
// ============================================================================
`default_nettype none

package lvds_phy_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } align_state_t;

    localparam int DEF_WINDOW       = 16;
    localparam int DEF_SLIP_SETTLE  = 4;
    localparam int DEF_LOCK_COUNT   = 4;
    localparam int DEF_UNLOCK_COUNT = 8;
    localparam int DEF_MAX_SLIPS    = 20;

    // K28.5 in both running disparities (abcdei_fghj bit order)
    localparam logic [9:0] K28_5_P = 10'b0011111010;
    localparam logic [9:0] K28_5_N = 10'b1100000101;

endpackage

`default_nettype wire

// File: rtl/lvds_phy_align_ctrl.sv
// ============================================================================
// lvds_phy_align_ctrl : bitslip-driven K28.5 word-alignment controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module lvds_phy_align_ctrl
    import lvds_phy_align_pkg::*;
#(
    parameter  int WINDOW       = DEF_WINDOW,
    parameter  int SLIP_SETTLE  = DEF_SLIP_SETTLE,
    parameter  int LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter  int UNLOCK_COUNT = DEF_UNLOCK_COUNT,
    parameter  int MAX_SLIPS    = DEF_MAX_SLIPS,
    localparam int SLIP_W       = $clog2(MAX_SLIPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rx_valid,
    input  logic              rx_comma,
    input  logic              rx_err,
    output logic              bitslip,
    output logic              aligned,
    output logic              align_fail,
    output logic              lock_lost,
    output logic [SLIP_W-1:0] slip_cnt,
    output logic [2:0]        state
);

    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int SET_W  = $clog2(SLIP_SETTLE + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(WINDOW);
    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SLIP_SETTLE - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);
    localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(UNLOCK_COUNT);
    localparam logic [SLIP_W-1:0] SLIP_MAX = SLIP_W'(MAX_SLIPS);

    align_state_t      state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d, win_inc;
    logic [SET_W-1:0]  set_q, set_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic [ERR_W-1:0]  err_q, err_d, err_inc;
    logic [SLIP_W-1:0] slip_q, slip_d, slip_inc;
    logic              bitslip_q, aligned_q, fail_q, lost_q, lost_d;

    // Saturating increments: counters hold at their terminal value
    assign win_inc  = (win_q  == WIN_MAX)  ? win_q  : win_q  + WIN_W'(1);
    assign good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
    assign err_inc  = (err_q  == ERR_MAX)  ? err_q  : err_q  + ERR_W'(1);
    assign slip_inc = (slip_q == SLIP_MAX) ? slip_q : slip_q + SLIP_W'(1);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        set_d   = set_q;
        good_d  = good_q;
        err_d   = err_q;
        slip_d  = slip_q;
        lost_d  = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            win_d   = '0;
            set_d   = '0;
            good_d  = '0;
            err_d   = '0;
            slip_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                    win_d   = '0;
                    good_d  = '0;
                    err_d   = '0;
                    slip_d  = '0;
                end
                ST_SEARCH: begin
                    if (rx_valid) begin
                        if (rx_comma && !rx_err) begin
                            state_d = ST_CHECK;
                            good_d  = GOOD_W'(1);
                            win_d   = '0;
                        end else if (win_inc == WIN_MAX) begin
                            state_d = ST_SLIP;
                            win_d   = '0;
                        end else begin
                            win_d   = win_inc;
                        end
                    end
                end
                ST_SLIP: begin
                    slip_d  = slip_inc;
                    set_d   = '0;
                    state_d = (slip_inc == SLIP_MAX) ? ST_FAIL : ST_SETTLE;
                end
                ST_SETTLE: begin
                    // rx_* deliberately ignored while the PHY boundary moves
                    if (set_q == SET_LAST) begin
                        state_d = ST_SEARCH;
                        win_d   = '0;
                    end else begin
                        set_d   = set_q + SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (rx_valid) begin
                        if (rx_err) begin
                            state_d = ST_SLIP;
                            win_d   = '0;
                            good_d  = '0;
                        end else if (rx_comma) begin
                            win_d  = '0;
                            good_d = good_inc;
                            if (good_inc == GOOD_MAX) begin
                                state_d = ST_LOCKED;
                                err_d   = '0;
                            end
                        end else if (win_inc == WIN_MAX) begin
                            state_d = ST_SLIP;
                            win_d   = '0;
                            good_d  = '0;
                        end else begin
                            win_d   = win_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rx_valid) begin
                        if (!rx_err) begin
                            err_d = '0;
                        end else if (err_inc == ERR_MAX) begin
                            state_d = ST_SEARCH;
                            lost_d  = 1'b1;
                            slip_d  = '0;
                            win_d   = '0;
                            good_d  = '0;
                            err_d   = '0;
                        end else begin
                            err_d   = err_inc;
                        end
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Flags are decoded from the next state so they align with the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            set_q     <= '0;
            good_q    <= '0;
            err_q     <= '0;
            slip_q    <= '0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
            fail_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            set_q     <= set_d;
            good_q    <= good_d;
            err_q     <= err_d;
            slip_q    <= slip_d;
            bitslip_q <= (state_d == ST_SLIP);
            aligned_q <= (state_d == ST_LOCKED);
            fail_q    <= (state_d == ST_FAIL);
            lost_q    <= lost_d;
        end
    end

    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign align_fail = fail_q;
    assign lock_lost  = lost_q;
    assign slip_cnt   = slip_q;
    assign state      = state_q;

endmodule

`default_nettype wire
